// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register indices, bus mode
// encodings and the debounce counter width.
package gpio_pkg;

    localparam logic [3:0] GPIO_REG_DIR      = 4'd0;
    localparam logic [3:0] GPIO_REG_OUT      = 4'd1;
    localparam logic [3:0] GPIO_REG_IN       = 4'd2;
    localparam logic [3:0] GPIO_REG_OUT_SET  = 4'd3;
    localparam logic [3:0] GPIO_REG_OUT_CLR  = 4'd4;
    localparam logic [3:0] GPIO_REG_OUT_TGL  = 4'd5;
    localparam logic [3:0] GPIO_REG_RISE_EN  = 4'd6;
    localparam logic [3:0] GPIO_REG_FALL_EN  = 4'd7;
    localparam logic [3:0] GPIO_REG_PEND     = 4'd8;
    localparam logic [3:0] GPIO_REG_DEBOUNCE = 4'd9;
    localparam int         GPIO_NUM_REGS     = 10;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'b00,
        BUS_READ  = 2'b01,
        BUS_WRITE = 2'b10,
        BUS_RSVD  = 2'b11
    } bus_mode_t;

    localparam int DEBOUNCE_WIDTH = 16;

endpackage

// File: rtl/gpio_debounce.sv
// One-pin debounce filter: a change on s must persist for thr+1 cycles
// before it reaches f, and the update cycle reports a rise or fall event.
module gpio_debounce
    import gpio_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s,
    input  logic [DEBOUNCE_WIDTH-1:0] thr,
    output logic                      f,
    output logic                      rise,
    output logic                      fall
);

    logic [DEBOUNCE_WIDTH-1:0] c;
    logic                      fire;

    assign fire = (s != f) && (c >= thr);
    assign rise = fire & s;
    assign fall = fire & ~s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f <= 1'b0;
            c <= '0;
        end else if (s == f) begin
            c <= '0;
        end else if (c >= thr) begin
            f <= s;
            c <= '0;
        end else begin
            c <= c + 1'b1;
        end
    end

endmodule

// File: rtl/synchronizer.sv
// Multi-stage flip-flop synchronizer for asynchronous pad inputs.
module synchronizer #(
    parameter int WIDTH      = 1,
    parameter int SYNC_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: register file, atomic output updates, debounced
// inputs with edge-capture interrupts and tri-state pad drivers.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h4040,
    parameter int          SYNC_DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      data_bus_write,
    output logic [15:0]      data_bus_read,
    input  logic [31:0]      data_bus_addr,
    input  logic [1:0]       data_bus_mode,
    input  logic             data_bus_select,
    inout  wire  [WIDTH-1:0] gpio_pins,
    output logic [WIDTH-1:0] gpio_pin_state,
    output logic             irq
);

    logic [WIDTH-1:0]          dir_r, out_r, rise_en, fall_en, pend;
    logic [DEBOUNCE_WIDTH-1:0] thr;
    logic [WIDTH-1:0]          sync_in, in_f, rise, fall, edge_evt, w1c;
    logic [WIDTH-1:0]          wdata;
    logic [31:0]               offset;
    logic [3:0]                reg_idx;
    logic                      reg_hit, wr_hit;
    logic [15:0]               rdata;

    // Registers are word-aligned; anything outside the ten slots is unmapped.
    assign offset  = data_bus_addr - BASE_ADDR;
    assign reg_hit = (offset[1:0] == 2'b00) && (offset[31:2] < 30'(GPIO_NUM_REGS));
    assign reg_idx = offset[5:2];
    assign wr_hit  = reg_hit && data_bus_select && (data_bus_mode == BUS_WRITE);
    assign wdata   = data_bus_write[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_r   <= '0;
            out_r   <= '0;
            rise_en <= '0;
            fall_en <= '0;
            thr     <= '0;
        end else if (wr_hit) begin
            case (reg_idx)
                GPIO_REG_DIR:      dir_r   <= wdata;
                GPIO_REG_OUT:      out_r   <= wdata;
                GPIO_REG_OUT_SET:  out_r   <= out_r | wdata;
                GPIO_REG_OUT_CLR:  out_r   <= out_r & ~wdata;
                GPIO_REG_OUT_TGL:  out_r   <= out_r ^ wdata;
                GPIO_REG_RISE_EN:  rise_en <= wdata;
                GPIO_REG_FALL_EN:  fall_en <= wdata;
                GPIO_REG_DEBOUNCE: thr     <= data_bus_write;
                default: ;
            endcase
        end
    end

    synchronizer #(
        .WIDTH      (WIDTH),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_pins),
        .q     (sync_in)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce u_deb (
            .clk   (clk),
            .reset (reset),
            .s     (sync_in[i]),
            .thr   (thr),
            .f     (in_f[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );

        assign gpio_pins[i] = dir_r[i] ? out_r[i] : 1'bz;
    end

    // A new edge is OR-ed in after the W1C mask, so it survives a same-cycle clear.
    assign edge_evt = ((rise & rise_en) | (fall & fall_en)) & ~dir_r;
    assign w1c      = (wr_hit && reg_idx == GPIO_REG_PEND) ? wdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~w1c) | edge_evt;
        end
    end

    always_comb begin
        rdata = '0;
        if (reg_hit) begin
            case (reg_idx)
                GPIO_REG_DIR:      rdata[WIDTH-1:0] = dir_r;
                GPIO_REG_OUT:      rdata[WIDTH-1:0] = out_r;
                GPIO_REG_IN:       rdata[WIDTH-1:0] = in_f;
                GPIO_REG_RISE_EN:  rdata[WIDTH-1:0] = rise_en;
                GPIO_REG_FALL_EN:  rdata[WIDTH-1:0] = fall_en;
                GPIO_REG_PEND:     rdata[WIDTH-1:0] = pend;
                GPIO_REG_DEBOUNCE: rdata = thr;
                default:           rdata = '0;
            endcase
        end
    end

    assign data_bus_read  = rdata;
    assign gpio_pin_state = in_f & ~dir_r;
    assign irq            = |pend;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: stimulus pushes expected values, a
// negedge monitor pops and compares them against the DUT.
module tb_gpio_bank;
    import gpio_pkg::*;

    localparam logic [31:0] BASE = 32'h4040;

    localparam int K_READ   = 0;
    localparam int K_IRQ    = 1;
    localparam int K_STATE  = 2;
    localparam int K_PADS   = 3;
    localparam int K_NARROW = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
    } chk_t;

    logic        clk;
    logic        reset;
    logic [15:0] data_bus_write;
    logic [15:0] data_bus_read;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic        data_bus_select;
    wire  [15:0] gpio_pins;
    logic [15:0] gpio_pin_state;
    logic        irq;
    logic [15:0] tb_en, tb_val;

    logic [15:0] narrow_read;
    wire  [4:0]  narrow_pins;
    logic [4:0]  narrow_state;
    logic        narrow_irq;

    chk_t sb[$];
    int   tests_run;
    int   tests_failed;
    logic chk_valid;

    gpio_bank dut (
        .clk             (clk),
        .reset           (reset),
        .data_bus_write  (data_bus_write),
        .data_bus_read   (data_bus_read),
        .data_bus_addr   (data_bus_addr),
        .data_bus_mode   (data_bus_mode),
        .data_bus_select (data_bus_select),
        .gpio_pins       (gpio_pins),
        .gpio_pin_state  (gpio_pin_state),
        .irq             (irq)
    );

    gpio_bank #(.WIDTH(5)) narrow (
        .clk             (clk),
        .reset           (reset),
        .data_bus_write  (data_bus_write),
        .data_bus_read   (narrow_read),
        .data_bus_addr   (data_bus_addr),
        .data_bus_mode   (data_bus_mode),
        .data_bus_select (data_bus_select),
        .gpio_pins       (narrow_pins),
        .gpio_pin_state  (narrow_state),
        .irq             (narrow_irq)
    );

    for (genvar i = 0; i < 16; i++) begin : g_pad
        assign gpio_pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] reg_addr(input logic [3:0] idx);
        return BASE + {26'd0, idx, 2'b00};
    endfunction

    // Monitor: whenever the bench flags an observation, pop and compare.
    always @(negedge clk) begin
        if (chk_valid) begin
            chk_t        e;
            logic [15:0] act;
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL scoreboard_empty: got observation, required a queued expectation");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    K_READ:   act = data_bus_read;
                    K_IRQ:    act = {15'd0, irq};
                    K_STATE:  act = gpio_pin_state;
                    K_PADS:   act = gpio_pins;
                    K_NARROW: act = narrow_read;
                    default:  act = 16'hDEAD;
                endcase
                tests_run++;
                if (act !== e.exp) begin
                    tests_failed++;
                    $display("[TB] FAIL %s: got %h, required %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] idx, input logic [15:0] data);
        data_bus_addr   = reg_addr(idx);
        data_bus_write  = data;
        data_bus_mode   = BUS_WRITE;
        data_bus_select = 1'b1;
        @(posedge clk);
        #1;
        data_bus_mode   = BUS_IDLE;
        data_bus_select = 1'b0;
    endtask

    task automatic check_output(input int kind, input logic [31:0] addr,
                                input logic [15:0] exp, input string name);
        chk_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
        data_bus_addr = addr;
        if (kind == K_READ || kind == K_NARROW) begin
            data_bus_mode   = BUS_READ;
            data_bus_select = 1'b1;
        end
        chk_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_valid       = 1'b0;
        data_bus_mode   = BUS_IDLE;
        data_bus_select = 1'b0;
    endtask

    task automatic check_reg(input logic [3:0] idx, input logic [15:0] exp, input string name);
        check_output(K_READ, reg_addr(idx), exp, name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        chk_valid       = 1'b0;
        reset           = 1'b0;
        tb_en           = 16'h0000;
        tb_val          = 16'h0000;
        data_bus_write  = 16'h0000;
        data_bus_addr   = 32'h0;
        data_bus_mode   = BUS_IDLE;
        data_bus_select = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);

        check_output(K_IRQ, 32'h0, 16'h0000, "post_reset_irq");
        apply_stimulus(GPIO_REG_DIR, 16'hFFFF);
        apply_stimulus(GPIO_REG_OUT, 16'h00FF);
        check_output(K_PADS, 32'h0, 16'h00FF, "pads_before_reset");
        check_reg(GPIO_REG_DIR, 16'hFFFF, "dir_before_reset");

        // Reset asserted right after an edge; first check lands before the next edge.
        reset = 1'b0;
        check_reg(GPIO_REG_DIR, 16'h0000, "reset_dir");
        check_reg(GPIO_REG_OUT, 16'h0000, "reset_out");
        check_output(K_IRQ, 32'h0, 16'h0000, "reset_irq");
        check_output(K_STATE, 32'h0, 16'h0000, "reset_pin_state");
        reset = 1'b1;
        idle(1);

        apply_stimulus(GPIO_REG_DIR, 16'h00F0);
        check_reg(GPIO_REG_DIR, 16'h00F0, "dir_readback");

        apply_stimulus(GPIO_REG_DIR, 16'hFFFF);
        check_output(K_NARROW, reg_addr(GPIO_REG_DIR), 16'h001F, "narrow_dir");
        check_output(K_NARROW, BASE + 32'd40, 16'h0000, "narrow_unmapped");
        check_reg(GPIO_REG_DIR, 16'hFFFF, "dir_all_out");
        apply_stimulus(GPIO_REG_OUT, 16'h00FF);
        apply_stimulus(GPIO_REG_OUT_SET, 16'h0F00);
        check_reg(GPIO_REG_OUT, 16'h0FFF, "out_after_set");
        check_output(K_PADS, 32'h0, 16'h0FFF, "pads_after_set");
        apply_stimulus(GPIO_REG_OUT_CLR, 16'h000F);
        check_reg(GPIO_REG_OUT, 16'h0FF0, "out_after_clr");
        check_output(K_PADS, 32'h0, 16'h0FF0, "pads_after_clr");
        apply_stimulus(GPIO_REG_OUT_TGL, 16'hF0F0);
        check_reg(GPIO_REG_OUT, 16'hFF00, "out_after_tgl");
        check_output(K_PADS, 32'h0, 16'hFF00, "pads_after_tgl");
        check_reg(GPIO_REG_OUT_SET, 16'h0000, "out_set_reads_zero");
        check_output(K_READ, BASE + 32'd40, 16'h0000, "unmapped_read");

        apply_stimulus(GPIO_REG_DIR, 16'h0000);
        tb_en  = 16'hFFFF;
        tb_val = 16'h0000;
        idle(8);
        check_reg(GPIO_REG_IN, 16'h0000, "in_idle");

        apply_stimulus(GPIO_REG_DEBOUNCE, 16'd5);
        apply_stimulus(GPIO_REG_RISE_EN, 16'h0001);
        check_reg(GPIO_REG_DEBOUNCE, 16'd5, "debounce_readback");

        tb_val[0] = 1'b1;
        idle(5);
        tb_val[0] = 1'b0;
        idle(20);
        check_reg(GPIO_REG_IN, 16'h0000, "glitch_in");
        check_reg(GPIO_REG_PEND, 16'h0000, "glitch_pend");

        // Six-cycle pulse: filtered input must flip on the ninth sampling edge.
        tb_val[0] = 1'b1;
        idle(6);
        tb_val[0] = 1'b0;
        idle(2);
        check_reg(GPIO_REG_IN, 16'h0000, "pulse_in_edge8");
        check_reg(GPIO_REG_IN, 16'h0001, "pulse_in_edge9");
        check_reg(GPIO_REG_PEND, 16'h0001, "pulse_pend");
        check_output(K_IRQ, 32'h0, 16'h0001, "pulse_irq");
        idle(20);
        apply_stimulus(GPIO_REG_PEND, 16'hFFFF);
        check_output(K_IRQ, 32'h0, 16'h0000, "pulse_irq_cleared");
        apply_stimulus(GPIO_REG_RISE_EN, 16'h0000);
        apply_stimulus(GPIO_REG_DEBOUNCE, 16'h0000);

        apply_stimulus(GPIO_REG_FALL_EN, 16'h0002);
        tb_val[1] = 1'b1;
        idle(8);
        check_reg(GPIO_REG_IN, 16'h0002, "edge_rise_in");
        check_reg(GPIO_REG_PEND, 16'h0000, "edge_rise_no_pend");
        tb_val[1] = 1'b0;
        idle(8);
        check_reg(GPIO_REG_PEND, 16'h0002, "edge_fall_pend");
        check_output(K_IRQ, 32'h0, 16'h0001, "edge_fall_irq");
        apply_stimulus(GPIO_REG_PEND, 16'h0002);
        check_reg(GPIO_REG_PEND, 16'h0000, "edge_fall_cleared");

        apply_stimulus(GPIO_REG_FALL_EN, 16'h0000);
        tb_en[1] = 1'b0;
        apply_stimulus(GPIO_REG_DIR, 16'h0002);
        apply_stimulus(GPIO_REG_OUT, 16'h0000);
        idle(8);
        apply_stimulus(GPIO_REG_FALL_EN, 16'h0002);
        apply_stimulus(GPIO_REG_RISE_EN, 16'h0002);
        apply_stimulus(GPIO_REG_OUT_SET, 16'h0002);
        idle(8);
        check_reg(GPIO_REG_IN, 16'h0002, "outpin_in_tracks");
        check_output(K_STATE, 32'h0, 16'h0000, "outpin_state_masked");
        apply_stimulus(GPIO_REG_OUT_CLR, 16'h0002);
        idle(8);
        check_reg(GPIO_REG_PEND, 16'h0000, "outpin_no_pend");
        check_output(K_IRQ, 32'h0, 16'h0000, "outpin_no_irq");
        apply_stimulus(GPIO_REG_RISE_EN, 16'h0000);
        apply_stimulus(GPIO_REG_FALL_EN, 16'h0000);
        apply_stimulus(GPIO_REG_DIR, 16'h0000);
        tb_en = 16'hFFFF;
        idle(8);

        apply_stimulus(GPIO_REG_RISE_EN, 16'h0004);
        tb_val[2] = 1'b1;
        idle(8);
        check_reg(GPIO_REG_PEND, 16'h0004, "race_first_pend");
        tb_val[2] = 1'b0;
        idle(8);
        check_reg(GPIO_REG_PEND, 16'h0004, "race_pend_sticky");
        // Rise lands on the fourth edge, the same edge as the W1C write.
        tb_val[2] = 1'b1;
        idle(3);
        apply_stimulus(GPIO_REG_PEND, 16'h0004);
        check_reg(GPIO_REG_PEND, 16'h0004, "race_event_wins");
        check_output(K_IRQ, 32'h0, 16'h0001, "race_irq_held");
        apply_stimulus(GPIO_REG_PEND, 16'h0004);
        check_output(K_IRQ, 32'h0, 16'h0000, "race_irq_drop");
        check_reg(GPIO_REG_PEND, 16'h0000, "race_pend_cleared");

        idle(5);
        if (sb.size() != 0) begin
            tests_run    += sb.size();
            tests_failed += sb.size();
            $display("[TB] FAIL scoreboard_drain: got %0d unchecked, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
